// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and ALU-side signals for alu_arbiter.
// slave is the arbiter's view; master is the requesters-plus-ALU environment.
interface alu_arbiter_if #(
  parameter int WIDTH = 6,
  parameter int OPW   = 2
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;
  logic             req0_ready;
  logic             rsp0_valid;
  logic [WIDTH-1:0] rsp0_result;
  logic             rsp0_flag;
  logic             rsp0_ready;

  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;
  logic             req1_ready;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp1_result;
  logic             rsp1_flag;
  logic             rsp1_ready;

  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_out;
  logic             alu_flag;
  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
    input  req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
    input  alu_out, alu_flag,
    output req0_ready, rsp0_valid, rsp0_result, rsp0_flag,
    output req1_ready, rsp1_valid, rsp1_result, rsp1_flag,
    output alu_in1, alu_in2, alu_op, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
    output req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
    output alu_out, alu_flag,
    input  req0_ready, rsp0_valid, rsp0_result, rsp0_flag,
    input  req1_ready, rsp1_valid, rsp1_result, rsp1_flag,
    input  alu_in1, alu_in2, alu_op, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters,
// with registered operands, captured result and per-requester response channels.
module alu_arbiter #(
  parameter int WIDTH = 6,
  parameter int OPW   = 2
) (
  input logic         clk,
  input logic         reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic             last_gnt_q, last_gnt_d;
  logic             gnt_id_q, gnt_id_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [WIDTH-1:0] in2_q, in2_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             flag_q, flag_d;

  logic any_valid;
  logic sel;
  logic rsp_ready_sel;

  assign any_valid = bus.req0_valid | bus.req1_valid;
  // Contention goes to whoever was not served last; otherwise the sole requester.
  assign sel = (bus.req0_valid & bus.req1_valid) ? ~last_gnt_q : bus.req1_valid;
  assign rsp_ready_sel = gnt_id_q ? bus.rsp1_ready : bus.rsp0_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      gnt_id_q   <= 1'b0;
      in1_q      <= '0;
      in2_q      <= '0;
      op_q       <= '0;
      res_q      <= '0;
      flag_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_id_q   <= gnt_id_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      op_q       <= op_d;
      res_q      <= res_d;
      flag_q     <= flag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_id_d   = gnt_id_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    op_d       = op_q;
    res_d      = res_q;
    flag_d     = flag_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          gnt_id_d = sel;
          in1_d    = sel ? bus.req1_a  : bus.req0_a;
          in2_d    = sel ? bus.req1_b  : bus.req0_b;
          op_d     = sel ? bus.req1_op : bus.req0_op;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        res_d   = bus.alu_out;
        flag_d  = bus.alu_flag;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_sel) begin
          last_gnt_d = gnt_id_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic in_idle;
  logic in_resp;
  assign in_idle = (state_q == IDLE) & ~reset;
  assign in_resp = (state_q == RESP);

  assign bus.req0_ready  = in_idle & bus.req0_valid & ~sel;
  assign bus.req1_ready  = in_idle & bus.req1_valid &  sel;
  assign bus.rsp0_valid  = in_resp & ~gnt_id_q;
  assign bus.rsp1_valid  = in_resp &  gnt_id_q;
  assign bus.rsp0_result = bus.rsp0_valid ? res_q : '0;
  assign bus.rsp1_result = bus.rsp1_valid ? res_q : '0;
  assign bus.rsp0_flag   = bus.rsp0_valid & flag_q;
  assign bus.rsp1_flag   = bus.rsp1_valid & flag_q;
  assign bus.alu_in1     = in1_q;
  assign bus.alu_in2     = in2_q;
  assign bus.alu_op      = op_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a stub ALU (op 00 = 6-bit add, flag = carry).
module tb_alu_arbiter;
  localparam int WIDTH = 6;
  localparam int OPW   = 2;

  logic clk;
  logic reset;
  int unsigned n_cmp;
  int unsigned n_err;

  alu_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH:0] stub_sum;
  always_comb begin
    stub_sum = {1'b0, bus.alu_in1} + {1'b0, bus.alu_in2};
    bus.alu_out  = '0;
    bus.alu_flag = 1'b0;
    case (bus.alu_op)
      2'b00: begin
        bus.alu_out  = stub_sum[WIDTH-1:0];
        bus.alu_flag = stub_sum[WIDTH];
      end
      2'b01:   bus.alu_out = bus.alu_in1 - bus.alu_in2;
      2'b10:   bus.alu_out = bus.alu_in1 & bus.alu_in2;
      default: bus.alu_out = bus.alu_in1 ^ bus.alu_in2;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  int exp_gnt;

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 6'd0; bus.req0_b = 6'd0; bus.req0_op = 2'b00;
    bus.req1_valid = 1'b1; bus.req1_a = 6'd0; bus.req1_b = 6'd0; bus.req1_op = 2'b00;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    tick(); tick();
    // Reset state: outputs quiet even with requests pending
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    chk("rst_busy",   bus.busy, 0);
    chk("rst_rsp0v",  bus.rsp0_valid, 0);
    chk("rst_rsp1v",  bus.rsp1_valid, 0);
    chk("rst_in1",    bus.alu_in1, 0);
    chk("rst_op",     bus.alu_op, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    reset = 1'b0;
    tick();

    // Single request 5+7
    bus.req0_valid = 1'b1; bus.req0_a = 6'd5; bus.req0_b = 6'd7; bus.req0_op = 2'b00;
    settle();
    chk("t1_ready0", bus.req0_ready, 1);
    chk("t1_ready1", bus.req1_ready, 0);
    chk("t1_busyT",  bus.busy, 0);
    tick();
    bus.req0_valid = 1'b0;
    settle();
    chk("t1_busyT1",  bus.busy, 1);
    chk("t1_rdyT1",   bus.req0_ready, 0);
    chk("t1_rspT1",   bus.rsp0_valid, 0);
    chk("t1_in1",     bus.alu_in1, 5);
    chk("t1_in2",     bus.alu_in2, 7);
    tick();
    chk("t1_rsp0v",   bus.rsp0_valid, 1);
    chk("t1_res",     bus.rsp0_result, 12);
    chk("t1_flag",    bus.rsp0_flag, 0);
    chk("t1_busyT2",  bus.busy, 1);
    chk("t1_rsp1v",   bus.rsp1_valid, 0);
    chk("t1_rsp1res", bus.rsp1_result, 0);
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
    chk("t1_idle_busy", bus.busy, 0);
    chk("t1_idle_rsp0", bus.rsp0_valid, 0);

    // Overflow 40+30 with back-pressure; req0 (9,9) waits
    bus.req1_valid = 1'b1; bus.req1_a = 6'd40; bus.req1_b = 6'd30; bus.req1_op = 2'b00;
    bus.req0_valid = 1'b1; bus.req0_a = 6'd9;  bus.req0_b = 6'd9;  bus.req0_op = 2'b00;
    settle();
    chk("t2_ready1", bus.req1_ready, 1);
    chk("t2_ready0", bus.req0_ready, 0);
    tick();
    bus.req1_valid = 1'b0;
    settle();
    chk("t2_exec_rdy0", bus.req0_ready, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_rsp1v",  bus.rsp1_valid, 1);
      chk("t2_res",    bus.rsp1_result, 6);
      chk("t2_flag",   bus.rsp1_flag, 1);
      chk("t2_rdy0",   bus.req0_ready, 0);
      chk("t2_rsp0v",  bus.rsp0_valid, 0);
      tick();
    end
    bus.rsp1_ready = 1'b1;
    settle();
    chk("t2_rdy0_consume", bus.req0_ready, 0);
    tick();
    bus.rsp1_ready = 1'b0;
    settle();
    chk("t2_rdy0_after", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    chk("t2_r0res", bus.rsp0_result, 18);
    chk("t2_r0v",   bus.rsp0_valid, 1);
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;

    // Simultaneous requests after reset; grants alternate starting with 0
    reset = 1'b1; settle(); reset = 1'b0;
    tick();
    bus.req0_valid = 1'b1; bus.req0_a = 6'd1; bus.req0_b = 6'd2; bus.req0_op = 2'b00;
    bus.req1_valid = 1'b1; bus.req1_a = 6'd3; bus.req1_b = 6'd4; bus.req1_op = 2'b00;
    exp_gnt = 0;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("t3_rdy0", bus.req0_ready, (exp_gnt == 0) ? 1 : 0);
      chk("t3_rdy1", bus.req1_ready, (exp_gnt == 1) ? 1 : 0);
      tick(); tick();
      if (exp_gnt == 0) begin
        chk("t3_v0",   bus.rsp0_valid, 1);
        chk("t3_res0", bus.rsp0_result, 3);
        bus.rsp0_ready = 1'b1;
      end else begin
        chk("t3_v1",   bus.rsp1_valid, 1);
        chk("t3_res1", bus.rsp1_result, 7);
        bus.rsp1_ready = 1'b1;
      end
      tick();
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
      exp_gnt = 1 - exp_gnt;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();

    // Reset during EXEC discards the response
    bus.req0_valid = 1'b1; bus.req0_a = 6'd10; bus.req0_b = 6'd10;
    tick();
    bus.req0_valid = 1'b0;
    reset = 1'b1;
    settle();
    chk("t4_busy",  bus.busy, 0);
    chk("t4_rsp0v", bus.rsp0_valid, 0);
    chk("t4_in1",   bus.alu_in1, 0);
    chk("t4_rdy0",  bus.req0_ready, 0);
    reset = 1'b0;
    tick();
    chk("t4_post_rsp0v", bus.rsp0_valid, 0);
    tick();
    chk("t4_post_rsp0v2", bus.rsp0_valid, 0);
    bus.req1_valid = 1'b1; bus.req1_a = 6'd2; bus.req1_b = 6'd2; bus.req1_op = 2'b00;
    settle();
    chk("t4_rdy1", bus.req1_ready, 1);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    chk("t4_v1",  bus.rsp1_valid, 1);
    chk("t4_res", bus.rsp1_result, 4);
    bus.rsp1_ready = 1'b1;
    tick();
    bus.rsp1_ready = 1'b0;

    // Idle hold with stray rsp_ready; operands keep last issue
    bus.rsp0_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t5_busy", bus.busy, 0);
      chk("t5_rdy0", bus.req0_ready, 0);
      chk("t5_rdy1", bus.req1_ready, 0);
      chk("t5_v0",   bus.rsp0_valid, 0);
      chk("t5_v1",   bus.rsp1_valid, 0);
      chk("t5_in1",  bus.alu_in1, 2);
      chk("t5_in2",  bus.alu_in2, 2);
      chk("t5_op",   bus.alu_op, 0);
      tick();
    end
    bus.rsp0_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 6-bit ALU between two independent requesters. Each requester hands over an operation (a, b, op) through a valid/ready handshake. The block arbitrates round-robin, drives the ALU from registered operands, captures the result, and returns it on a per-requester response channel with back-pressure. It sits between the requesting front-ends and the existing ALU, replacing direct per-requester wiring.

## Interface
Parameters:
- WIDTH, 6: operand and result width; must match the ALU.
- OPW, 2: opcode width.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- req0_valid, input, 1: requester 0 has an operation pending.
- req0_a, input, WIDTH: requester 0 operand a.
- req0_b, input, WIDTH: requester 0 operand b.
- req0_op, input, OPW: requester 0 opcode.
- req0_ready, output, 1: requester 0 operation is accepted this cycle.
- rsp0_valid, output, 1: response for requester 0 is available.
- rsp0_result, output, WIDTH: result returned to requester 0.
- rsp0_flag, output, 1: ALU flag returned to requester 0.
- rsp0_ready, input, 1: requester 0 consumes the response.
- req1_* and rsp1_*: identical set of signals for requester 1.
- alu_in1, output, WIDTH: ALU operand a.
- alu_in2, output, WIDTH: ALU operand b.
- alu_op, output, OPW: ALU opcode.
- alu_out, input, WIDTH: ALU result (combinational from alu_in1, alu_in2, alu_op).
- alu_flag, input, 1: ALU flag.
- busy, output, 1: high in any state other than IDLE.

## Operation
The FSM has three states: IDLE, EXEC, RESP. A 1-bit register last_gnt records the last requester served; reset sets it to 1, so requester 0 wins first.

- **IDLE**
  - Select a requester:
    - Only one reqN_valid is high: select that requester.
    - Both are high: select the requester that is not last_gnt.
    - Neither is high: stay in IDLE.
  - reqN_ready is combinational, high only for the selected requester, and only while in IDLE.
  - On valid&ready, register a, b and op into alu_in1, alu_in2 and alu_op.
  - Record the selected requester in gnt_id and go to EXEC.
- **EXEC** (exactly 1 cycle)
  - The ALU settles on the registered operands.
  - At the end of the cycle, capture alu_out and alu_flag into the result and flag registers, then go to RESP.
- **RESP**
  - rsp[gnt_id]_valid is high; rsp[gnt_id]_result and rsp[gnt_id]_flag hold the captured values.
  - The other requester's rsp_valid stays 0.
  - On rsp[gnt_id]_ready: set last_gnt to gnt_id and go to IDLE.
  - Without rsp_ready, hold indefinitely with result and flag stable.
- While not in IDLE, both reqN_ready outputs are 0. Requests arriving in EXEC or RESP wait; requesters must hold valid and payload until ready.
- alu_in1, alu_in2 and alu_op change only at an accept; they hold their value after the response.
- Undriven rspN_result and rspN_flag outputs read 0 whenever rspN_valid is 0.
- An illegal state encoding recovers to IDLE on the next edge.

## Timing
- Reset values: state IDLE, last_gnt 1, gnt_id 0, alu_in1/alu_in2/alu_op 0, captured result and flag 0.
- Output values during reset: all reqN_ready, rspN_valid and busy are 0.
- Reset mid-operation (EXEC or RESP): return to IDLE immediately. Any in-flight response is discarded and never presented.
- Latency: accept in cycle T (IDLE); EXEC in T+1; rsp_valid is first high in T+2.
- Response back-to-back: if rsp_ready is high in T+2, the next accept can occur no earlier than T+3.
- Minimum issue interval is 3 cycles per operation.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- A requester whose valid drops before it is accepted loses nothing; the other requester may be served.
- rspN_ready asserted when no response is pending for that requester has no effect.

## Test plan
The bench uses a stub ALU: op 00 gives a+b truncated to 6 bits, with flag = carry out.

- Single request: req0 a=5, b=7, op=00 at T -> req0_ready high at T, rsp0_valid at T+2 with result 12, flag 0, busy high for T+1..T+2.
- Overflow and back-pressure: req1 a=40, b=30, op=00; rsp1_ready held low for 5 cycles -> rsp1_result 6, flag 1, stable throughout; req0 held valid during this time sees ready 0 until the cycle after rsp1 is consumed.
- Simultaneous requests after reset: req0 (1,2) and req1 (3,4) both valid at T -> req0 granted first (result 3), then req1 (result 7); on repeated pairs, grants alternate 0,1,0,1.
- Reset mid-operation: assert reset during EXEC of req0 -> all outputs 0 at once; after release, no rsp0_valid appears; a new req1 (2,2) returns 4 at T+2.
- Idle hold: no requests for 10 cycles -> busy, reqN_ready and rspN_valid all 0; alu_in1, alu_in2 and alu_op keep the last issued values.
